// File: rtl/norm_pkg.sv
// Shared types and helpers for the perspective-divide stage.
// Optional z divide is selected by the NORM_Z_DIVIDE_EN macro in the top level.
package norm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

  // Low bit of vertex i inside a packed coordinate bus.
  function automatic int vtx_lo(input int i, input int dw);
    return i * dw;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring signed divider, one quotient bit per cycle, fixed latency DATA_W+FRAC_W.
// Computes (num <<< FRAC_W) / den on magnitudes, truncating toward zero, saturating to DATA_W.
module seq_divider
  import norm_pkg::*;
#(
  parameter int DATA_W = 21,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     div_start,
  input  logic signed [DATA_W-1:0] num,
  input  logic signed [DATA_W-1:0] den,
  output logic signed [DATA_W-1:0] quot,
  output logic                     div0,
  output logic                     div_done
);

  localparam int Q_W   = DATA_W + FRAC_W;
  localparam int CNT_W = $clog2(Q_W + 1);
  localparam logic signed [DATA_W-1:0] Q_MAX = DATA_W'(sat_max(DATA_W));
  localparam logic signed [DATA_W-1:0] Q_MIN = DATA_W'(sat_min(DATA_W));
  localparam logic [Q_W-1:0] MAG_POS = Q_W'(sat_max(DATA_W));
  localparam logic [Q_W-1:0] MAG_NEG = Q_W'(-sat_min(DATA_W));

  logic [DATA_W-1:0] r_rem;
  logic [Q_W-1:0]    r_dq;
  logic [DATA_W-1:0] r_den_mag;
  logic              r_neg;
  logic              r_num_neg;
  logic              r_num_zero;
  logic              r_den_zero;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_done;

  logic [DATA_W-1:0] w_num_mag;
  logic [DATA_W-1:0] w_den_mag;
  logic [DATA_W-1:0] w_src_rem;
  logic [Q_W-1:0]    w_src_dq;
  logic [DATA_W-1:0] w_src_den;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W:0]   w_sub;
  logic              w_ge;
  logic [DATA_W-1:0] w_next_rem;
  logic [Q_W-1:0]    w_next_dq;

  assign w_num_mag = num[DATA_W-1] ? -num : num;
  assign w_den_mag = den[DATA_W-1] ? -den : den;

  // The first iteration runs on the start edge so div_done lands Q_W cycles later.
  assign w_src_rem  = div_start ? '0 : r_rem;
  assign w_src_dq   = div_start ? (Q_W'(w_num_mag) << FRAC_W) : r_dq;
  assign w_src_den  = div_start ? w_den_mag : r_den_mag;
  assign w_trial    = {w_src_rem, w_src_dq[Q_W-1]};
  assign w_sub      = w_trial - {1'b0, w_src_den};
  assign w_ge       = (w_trial >= {1'b0, w_src_den});
  assign w_next_rem = w_ge ? w_sub[DATA_W-1:0] : w_trial[DATA_W-1:0];
  assign w_next_dq  = {w_src_dq[Q_W-2:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem      <= '0;
      r_dq       <= '0;
      r_den_mag  <= '0;
      r_neg      <= 1'b0;
      r_num_neg  <= 1'b0;
      r_num_zero <= 1'b0;
      r_den_zero <= 1'b0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (div_start) begin
        r_rem      <= w_next_rem;
        r_dq       <= w_next_dq;
        r_den_mag  <= w_den_mag;
        r_neg      <= num[DATA_W-1] ^ den[DATA_W-1];
        r_num_neg  <= num[DATA_W-1];
        r_num_zero <= (num == '0);
        r_den_zero <= (den == '0);
        r_cnt      <= CNT_W'(Q_W - 1);
        r_done     <= (Q_W == 1);
      end else if (r_cnt != '0) begin
        r_rem <= w_next_rem;
        r_dq  <= w_next_dq;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) r_done <= 1'b1;
      end
    end
  end

  always_comb begin
    quot = '0;
    if (r_den_zero) begin
      if (!r_num_zero) quot = r_num_neg ? Q_MIN : Q_MAX;
    end else if (r_neg) begin
      quot = (r_dq > MAG_NEG) ? Q_MIN : -$signed(r_dq[DATA_W-1:0]);
    end else begin
      quot = (r_dq > MAG_POS) ? Q_MAX : $signed(r_dq[DATA_W-1:0]);
    end
  end

  assign div0     = r_den_zero;
  assign div_done = r_done;

endmodule

// File: rtl/perspective_divide.sv
// Perspective divide: x/w, y/w (and z/w with NORM_Z_DIVIDE_EN) for NUM_VTX vertices
// through one shared sequential divider; results commit together on the DONE edge.
module perspective_divide
  import norm_pkg::*;
#(
  parameter int DATA_W  = 21,
  parameter int FRAC_W  = 8,
  parameter int NUM_VTX = 4
) (
  input  logic                      CLK,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_VTX*DATA_W-1:0] x_in,
  input  logic [NUM_VTX*DATA_W-1:0] y_in,
  input  logic [NUM_VTX*DATA_W-1:0] z_in,
  input  logic [NUM_VTX*DATA_W-1:0] w_in,
  output logic [NUM_VTX*DATA_W-1:0] x_out,
  output logic [NUM_VTX*DATA_W-1:0] y_out,
  output logic [NUM_VTX*DATA_W-1:0] z_out,
  output logic [NUM_VTX-1:0]        div0,
  output logic                      busy,
  output logic                      done,
  output state_t                    dbg_state
);

`ifdef NORM_Z_DIVIDE_EN
  localparam int OPS = 3;
`else
  localparam int OPS = 2;
`endif
  localparam int VTX_W = (NUM_VTX > 1) ? $clog2(NUM_VTX) : 1;
  localparam int VW    = NUM_VTX * DATA_W;

  state_t r_state, w_next_state;

  logic [VW-1:0]      r_x, r_y, r_z, r_w;
  logic [VW-1:0]      r_sh_x, r_sh_y, r_sh_z;
  logic [NUM_VTX-1:0] r_sh_div0;
  logic [VTX_W-1:0]   r_vtx;
  logic [1:0]         r_op;

  logic                     w_div_start;
  logic                     w_div_done;
  logic                     w_div0;
  logic                     w_last_op;
  logic signed [DATA_W-1:0] w_num;
  logic signed [DATA_W-1:0] w_den;
  logic signed [DATA_W-1:0] w_quot;

  seq_divider #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_div (
    .clk       (CLK),
    .rst       (rst),
    .div_start (w_div_start),
    .num       (w_num),
    .den       (w_den),
    .quot      (w_quot),
    .div0      (w_div0),
    .div_done  (w_div_done)
  );

  always_comb begin
    w_den = r_w[vtx_lo(int'(r_vtx), DATA_W) +: DATA_W];
    w_num = r_x[vtx_lo(int'(r_vtx), DATA_W) +: DATA_W];
    case (r_op)
      2'd1:    w_num = r_y[vtx_lo(int'(r_vtx), DATA_W) +: DATA_W];
      2'd2:    w_num = r_z[vtx_lo(int'(r_vtx), DATA_W) +: DATA_W];
      default: w_num = r_x[vtx_lo(int'(r_vtx), DATA_W) +: DATA_W];
    endcase
  end

  assign w_last_op = (r_op == 2'(OPS - 1)) && (r_vtx == VTX_W'(NUM_VTX - 1));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Handshake: start is only looked at in IDLE (no queuing); done pulses for one
  // cycle in DONE, and the committed outputs are visible from the following cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  if (w_div_done) w_next_state = S_STORE;
      S_STORE: w_next_state = w_last_op ? S_DONE : S_ISSUE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_div_start = (r_state == S_ISSUE);
  assign busy        = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_STORE);
  assign done        = (r_state == S_DONE);
  assign dbg_state   = r_state;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_w       <= '0;
      r_sh_x    <= '0;
      r_sh_y    <= '0;
      r_sh_z    <= '0;
      r_sh_div0 <= '0;
      r_vtx     <= '0;
      r_op      <= '0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      div0      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x   <= x_in;
            r_y   <= y_in;
            r_z   <= z_in;
            r_w   <= w_in;
            r_vtx <= '0;
            r_op  <= '0;
          end
        end
        S_STORE: begin
          case (r_op)
            2'd1:    r_sh_y[vtx_lo(int'(r_vtx), DATA_W) +: DATA_W] <= w_quot;
            2'd2:    r_sh_z[vtx_lo(int'(r_vtx), DATA_W) +: DATA_W] <= w_quot;
            default: r_sh_x[vtx_lo(int'(r_vtx), DATA_W) +: DATA_W] <= w_quot;
          endcase
          r_sh_div0[r_vtx] <= w_div0;
          if (r_op == 2'(OPS - 1)) begin
            r_op  <= '0;
            r_vtx <= r_vtx + 1'b1;
          end else begin
            r_op <= r_op + 1'b1;
          end
        end
        S_DONE: begin
          x_out <= r_sh_x;
          y_out <= r_sh_y;
          div0  <= r_sh_div0;
`ifdef NORM_Z_DIVIDE_EN
          z_out <= r_sh_z;
`else
          // Depth test downstream consumes the raw w as depth.
          z_out <= r_w;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perspective_divide.sv
// Directed, table-driven bench for perspective_divide: results, latency, busy length,
// ignored mid-run start and asynchronous reset in mid-frame.
module tb_perspective_divide;
  import norm_pkg::*;

  localparam int DW = 21;
  localparam int FW = 8;
  localparam int NV = 4;
  localparam int QW = DW + FW;
  localparam int VW = NV * DW;
`ifdef NORM_Z_DIVIDE_EN
  localparam int OPS = 3;
`else
  localparam int OPS = 2;
`endif
  localparam int EXP_DONE = NV * OPS * (QW + 2) + 1;
  localparam int EXP_BUSY = EXP_DONE - 1;
  localparam int TIMEOUT  = 2000;

  logic          CLK;
  logic          rst;
  logic          start;
  logic [VW-1:0] x_in, y_in, z_in, w_in;
  logic [VW-1:0] x_out, y_out, z_out;
  logic [NV-1:0] div0;
  logic          busy;
  logic          done;
  state_t        dbg_state;

  perspective_divide #(.DATA_W(DW), .FRAC_W(FW), .NUM_VTX(NV)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .w_in      (w_in),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out),
    .div0      (div0),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [VW-1:0] x, y, z, w;
    logic [VW-1:0] ex, ey, ezq;
    logic [NV-1:0] ed0;
  } vec_t;

  vec_t vt[4];

  function automatic logic [VW-1:0] p4(input int v0, input int v1, input int v2, input int v3);
    return {v3[DW-1:0], v2[DW-1:0], v1[DW-1:0], v0[DW-1:0]};
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input string tag);
    logic [VW-1:0] ez;
`ifdef NORM_Z_DIVIDE_EN
    ez = vt[idx].ezq;
`else
    ez = vt[idx].w;
`endif
    chk({tag, ".x_out"}, x_out, vt[idx].ex);
    chk({tag, ".y_out"}, y_out, vt[idx].ey);
    chk({tag, ".z_out"}, z_out, ez);
    chk({tag, ".div0"}, VW'(div0), VW'(vt[idx].ed0));
  endtask

  // Driver: one frame. poke_kind 1 re-pulses start with new inputs at poke_cyc,
  // poke_kind 2 asserts rst at poke_cyc and ends the frame there.
  task automatic run_frame(input int idx, input int poke_cyc, input int poke_kind,
                           output int done_cyc, output int busy_cyc, output bit stable);
    logic [VW-1:0] px, py, pz;
    logic [NV-1:0] pd;
    int cyc;
    px = x_out; py = y_out; pz = z_out; pd = div0;
    done_cyc = -1; busy_cyc = 0; stable = 1'b1;
    @(negedge CLK);
    x_in = vt[idx].x; y_in = vt[idx].y; z_in = vt[idx].z; w_in = vt[idx].w;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc <= TIMEOUT) begin
      if (busy) busy_cyc++;
      if (x_out !== px || y_out !== py || z_out !== pz || div0 !== pd) stable = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == poke_cyc && poke_kind == 1) begin
        start = 1'b1;
        x_in = vt[2].x; y_in = vt[2].y; z_in = vt[2].z; w_in = vt[2].w;
      end
      if (cyc == poke_cyc && poke_kind == 2) begin
        rst = 1'b1;
        #1;
        chk("midrst.x_out", x_out, '0);
        chk("midrst.y_out", y_out, '0);
        chk("midrst.z_out", z_out, '0);
        chk("midrst.div0", VW'(div0), '0);
        chk_int("midrst.busy", int'(busy), 0);
        chk_int("midrst.done", int'(done), 0);
        @(negedge CLK);
        rst = 1'b0;
        return;
      end
      @(posedge CLK); #1;
      start = 1'b0;
      cyc++;
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: no done within %0d cycles", TIMEOUT);
    end else begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    int  dc, bc;
    bit  st;
    rst = 1'b1; start = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; w_in = '0;

    vt[0] = '{x: p4(512, 1, -1, 5), y: p4(0, 0, 0, -5), z: p4(768, 3, -3, 0),
              w: p4(256, 3, 3, 0),
              ex: p4(512, 85, -85, 1048575), ey: p4(0, 0, 0, -1048576),
              ezq: p4(768, 256, -256, 0), ed0: 4'b1000};
    vt[1] = '{x: p4(1048575, -1048576, -768, 100), y: p4(0, 1000, 256, 0),
              z: p4(0, 0, 0, 0), w: p4(1, 1, -256, -7),
              ex: p4(1048575, -1048576, 768, -3657), ey: p4(0, 256000, -256, 0),
              ezq: p4(0, 0, 0, 0), ed0: 4'b0000};
    vt[2] = '{x: p4(0, -3, 7, 0), y: p4(1, 0, -1, -1048576), z: p4(5, 0, 0, -5),
              w: p4(0, 0, 0, 0),
              ex: p4(0, -1048576, 1048575, 0), ey: p4(1048575, 0, -1048576, -1048576),
              ezq: p4(1048575, 0, 0, -1048576), ed0: 4'b1111};
    vt[3] = '{x: p4(-1048576, 1, -1048576, 3), y: p4(1048575, -1, 0, -3),
              z: p4(0, 0, 0, 0), w: p4(-1048576, 1048575, 1048575, 2),
              ex: p4(256, 0, -256, 384), ey: p4(-255, 0, 0, -384),
              ezq: p4(0, 0, 0, 0), ed0: 4'b0000};

    repeat (3) @(posedge CLK);
    #1;
    chk("reset.x_out", x_out, '0);
    chk("reset.y_out", y_out, '0);
    chk("reset.z_out", z_out, '0);
    chk("reset.div0", VW'(div0), '0);
    chk_int("reset.busy", int'(busy), 0);
    chk_int("reset.done", int'(done), 0);
    @(negedge CLK);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_frame(i, -1, 0, dc, bc, st);
      chk_int($sformatf("vec%0d.done_cycle", i), dc, EXP_DONE);
      chk_int($sformatf("vec%0d.busy_cycles", i), bc, EXP_BUSY);
      chk_int($sformatf("vec%0d.hold_before_done", i), int'(st), 1);
      check_outputs(i, $sformatf("vec%0d", i));
      chk_int($sformatf("vec%0d.done_low_after", i), int'(done), 0);
    end

    // Start re-pulsed mid-frame with different inputs must be ignored.
    run_frame(0, 100, 1, dc, bc, st);
    chk_int("restart.done_cycle", dc, EXP_DONE);
    chk_int("restart.hold_before_done", int'(st), 1);
    check_outputs(0, "restart");

    // Reset in mid-frame, then a fresh frame completes with full latency.
    run_frame(1, 120, 2, dc, bc, st);
    repeat (2) @(posedge CLK);
    run_frame(3, -1, 0, dc, bc, st);
    chk_int("afterrst.done_cycle", dc, EXP_DONE);
    chk_int("afterrst.busy_cycles", bc, EXP_BUSY);
    check_outputs(3, "afterrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
